// File: rtl/cache_miss_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_refill_ctrl
//   Turns a cache-miss pulse into a line refill. It issues one request for the
//   line base address, then writes BEATS response beats into the cache, one
//   write strobe per beat. One further miss can wait in a pending slot. Misses
//   beyond that are dropped and flagged in a sticky overflow bit.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   miss_pulse, miss_addr         miss event and the missing address
//   mem_req_valid/ready/addr      refill request handshake (line base)
//   mem_rsp_valid, mem_rsp_data   response beats
//   refill_we/addr/data           registered cache write port
//   refill_busy, refill_done      status: not idle / line-complete pulse
//   clr_overflow, overflow        sticky dropped-miss flag and its clear
// -----------------------------------------------------------------------------
module cache_miss_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_pulse,
   input  logic [ADDR_W-1:0] miss_addr,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rsp_data,
   output logic              refill_we,
   output logic [ADDR_W-1:0] refill_addr,
   output logic [DATA_W-1:0] refill_data,
   output logic              refill_busy,
   output logic              refill_done,
   input  logic              clr_overflow,
   output logic              overflow
);

   localparam int IDX_W = $clog2(BEATS);

   typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] base_reg;
   logic [ADDR_W-1:0] pend_base_reg;
   logic              pend_valid_reg;
   logic [IDX_W-1:0]  beat_cnt_reg;
   logic              overflow_reg;
   logic              refill_we_reg;
   logic [ADDR_W-1:0] refill_addr_reg;
   logic [DATA_W-1:0] refill_data_reg;

   logic [ADDR_W-1:0] miss_base;
   logic              beat_accept;
   logic              last_beat;
   logic              slot_store;
   logic              slot_consume;
   logic              drop;

   assign miss_base   = {miss_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
   assign beat_accept = (state_reg == FILL) && mem_rsp_valid;
   assign last_beat   = (beat_cnt_reg == IDX_W'(BEATS - 1));

   // The slot is drained whenever the FSM can start a new line: in DONE, and
   // in IDLE for a miss that arrived during a DONE cycle with the slot empty.
   assign slot_consume = pend_valid_reg && ((state_reg == DONE) || (state_reg == IDLE));

   // A miss goes into the slot when the FSM is busy and the slot is free, or
   // when the slot is being drained in the same cycle (DONE, or IDLE while the
   // slot entry is promoted to the active line).
   always_comb begin
      slot_store = 1'b0;
      drop       = 1'b0;
      if (miss_pulse) begin
         if (state_reg == IDLE) begin
            slot_store = pend_valid_reg;
         end else if (!pend_valid_reg || (state_reg == DONE)) begin
            slot_store = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (miss_pulse || pend_valid_reg) state_next = REQ;
         REQ:     if (mem_req_ready) state_next = FILL;
         FILL:    if (beat_accept && last_beat) state_next = DONE;
         DONE:    state_next = pend_valid_reg ? REQ : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      mem_req_valid = (state_reg == REQ);
      refill_busy   = (state_reg != IDLE);
      refill_done   = (state_reg == DONE);
   end

   assign mem_req_addr = base_reg;
   assign refill_we    = refill_we_reg;
   assign refill_addr  = refill_addr_reg;
   assign refill_data  = refill_data_reg;
   assign overflow     = overflow_reg;

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_reg        <= '0;
         pend_base_reg   <= '0;
         pend_valid_reg  <= 1'b0;
         beat_cnt_reg    <= '0;
         overflow_reg    <= 1'b0;
         refill_we_reg   <= 1'b0;
         refill_addr_reg <= '0;
         refill_data_reg <= '0;
      end else begin
         // Active line base: slot entry has priority over a fresh miss.
         if (slot_consume)
            base_reg <= pend_base_reg;
         else if ((state_reg == IDLE) && miss_pulse)
            base_reg <= miss_base;

         if (slot_store)
            pend_base_reg <= miss_base;
         if (slot_store)
            pend_valid_reg <= 1'b1;
         else if (slot_consume)
            pend_valid_reg <= 1'b0;

         if ((state_reg == REQ) && mem_req_ready)
            beat_cnt_reg <= '0;
         else if (beat_accept)
            beat_cnt_reg <= beat_cnt_reg + 1'b1;

         // A drop in the same cycle as a clear leaves the flag set.
         if (drop)
            overflow_reg <= 1'b1;
         else if (clr_overflow)
            overflow_reg <= 1'b0;

         refill_we_reg <= beat_accept;
         if (beat_accept) begin
            refill_data_reg <= mem_rsp_data;
            refill_addr_reg <= base_reg | {{(ADDR_W-IDX_W){1'b0}}, beat_cnt_reg};
         end
      end
   end

endmodule

// File: tb/tb_cache_miss_refill_ctrl.sv
module tb_cache_miss_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_pulse;
   logic [31:0] miss_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic        refill_we;
   logic [31:0] refill_addr;
   logic [63:0] refill_data;
   logic        refill_busy;
   logic        refill_done;
   logic        clr_overflow;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int n_writes = 0;
   int n_done = 0;

   cache_miss_refill_ctrl #(.ADDR_W(32), .DATA_W(64), .BEATS(4)) dut (
      .clk(clk), .rst(rst),
      .miss_pulse(miss_pulse), .miss_addr(miss_addr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .refill_we(refill_we), .refill_addr(refill_addr), .refill_data(refill_data),
      .refill_busy(refill_busy), .refill_done(refill_done),
      .clr_overflow(clr_overflow), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (refill_we === 1'b1)   n_writes++;
      if (refill_done === 1'b1) n_done++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one clock edge, then settle before sampling/driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic [31:0] exp_addr, input logic exp_done, input string tag);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      tick();
      mem_rsp_valid = 1'b0;
      miss_pulse    = 1'b0;
      check({tag, "_we"},   64'(refill_we), 64'd1);
      check({tag, "_addr"}, 64'(refill_addr), 64'(exp_addr));
      check({tag, "_data"}, refill_data, d);
      check({tag, "_done"}, 64'(refill_done), 64'(exp_done));
   endtask

   initial begin
      rst = 1'b1; miss_pulse = 0; miss_addr = 0; mem_req_ready = 0;
      mem_rsp_valid = 0; mem_rsp_data = 0; clr_overflow = 0;
      tick(); tick();
      check("rst_valid", 64'(mem_req_valid), 64'd0);
      check("rst_we",    64'(refill_we), 64'd0);
      check("rst_busy",  64'(refill_busy), 64'd0);
      check("rst_done",  64'(refill_done), 64'd0);
      check("rst_ovf",   64'(overflow), 64'd0);
      check("rst_raddr", 64'(mem_req_addr), 64'd0);
      rst = 1'b0;
      tick();

      // ---- basic line: miss 0x1007, back-to-back beats ----
      miss_pulse = 1; miss_addr = 32'h1007;
      tick();
      miss_pulse = 0;
      check("t1_req_valid", 64'(mem_req_valid), 64'd1);
      check("t1_req_addr",  64'(mem_req_addr), 64'h1004);
      check("t1_busy",      64'(refill_busy), 64'd1);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      check("t1_fill_valid", 64'(mem_req_valid), 64'd0);
      beat(64'hD0, 32'h1004, 1'b0, "t1_b0");
      beat(64'hD1, 32'h1005, 1'b0, "t1_b1");
      beat(64'hD2, 32'h1006, 1'b0, "t1_b2");
      beat(64'hD3, 32'h1007, 1'b1, "t1_b3");
      tick();
      check("t1_end_we",   64'(refill_we), 64'd0);
      check("t1_end_done", 64'(refill_done), 64'd0);
      check("t1_end_busy", 64'(refill_busy), 64'd0);
      check("t1_writes",   64'(n_writes), 64'd4);
      check("t1_ndone",    64'(n_done), 64'd1);

      // ---- spurious beat in IDLE ----
      mem_rsp_valid = 1; mem_rsp_data = 64'hBAD;
      tick();
      mem_rsp_valid = 0;
      check("t2_idle_we",   64'(refill_we), 64'd0);
      check("t2_idle_busy", 64'(refill_busy), 64'd0);

      // ---- ready held low for 5 cycles ----
      miss_pulse = 1; miss_addr = 32'h3009;
      tick();
      miss_pulse = 0;
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", 64'(mem_req_valid), 64'd1);
         check("t2_hold_addr",  64'(mem_req_addr), 64'h3008);
         tick();
      end
      check("t2_still_req", 64'(mem_req_valid), 64'd1);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;

      // ---- beats with 2-cycle gaps ----
      for (int i = 0; i < 4; i++) begin
         beat(64'hA0 + 64'(i), 32'h3008 + 32'(i), (i == 3) ? 1'b1 : 1'b0, "t3_b");
         tick();
         check("t3_gap_we", 64'(refill_we), 64'd0);
         tick();
      end
      check("t3_writes", 64'(n_writes), 64'd8);
      check("t3_idle",   64'(refill_busy), 64'd0);

      // ---- pending slot and overflow ----
      miss_pulse = 1; miss_addr = 32'h1000;
      tick();
      miss_pulse = 0;
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      beat(64'hE0, 32'h1000, 1'b0, "t4_b0");
      miss_pulse = 1; miss_addr = 32'h2000;
      beat(64'hE1, 32'h1001, 1'b0, "t4_b1");
      check("t4_ovf_slot", 64'(overflow), 64'd0);
      miss_pulse = 1; miss_addr = 32'h5000;
      beat(64'hE2, 32'h1002, 1'b0, "t4_b2");
      check("t4_ovf_drop", 64'(overflow), 64'd1);
      beat(64'hE3, 32'h1003, 1'b1, "t4_b3");
      tick();
      check("t4_next_valid", 64'(mem_req_valid), 64'd1);
      check("t4_next_addr",  64'(mem_req_addr), 64'h2000);
      check("t4_next_busy",  64'(refill_busy), 64'd1);
      check("t4_ovf_sticky", 64'(overflow), 64'd1);
      clr_overflow = 1;
      tick();
      clr_overflow = 0;
      check("t4_ovf_clr", 64'(overflow), 64'd0);
      // fill the slot, then drop with a simultaneous clear
      miss_pulse = 1; miss_addr = 32'h6001;
      tick();
      miss_pulse = 1; miss_addr = 32'h7000; clr_overflow = 1;
      tick();
      miss_pulse = 0; clr_overflow = 0;
      check("t4_drop_wins", 64'(overflow), 64'd1);
      clr_overflow = 1;
      tick();
      clr_overflow = 0;
      check("t4_ovf_clr2", 64'(overflow), 64'd0);
      check("t4_req_hold", 64'(mem_req_addr), 64'h2000);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      beat(64'hF0, 32'h2000, 1'b0, "t4_c0");
      beat(64'hF1, 32'h2001, 1'b0, "t4_c1");
      beat(64'hF2, 32'h2002, 1'b0, "t4_c2");
      beat(64'hF3, 32'h2003, 1'b1, "t4_c3");
      tick();
      check("t4_slot_valid", 64'(mem_req_valid), 64'd1);
      check("t4_slot_addr",  64'(mem_req_addr), 64'h6000);

      // ---- reset mid-refill ----
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      beat(64'h10, 32'h6000, 1'b0, "t5_b0");
      miss_pulse = 1; miss_addr = 32'h9000;
      beat(64'h11, 32'h6001, 1'b0, "t5_b1");
      miss_pulse = 1; miss_addr = 32'hA000;
      tick();
      miss_pulse = 0;
      check("t5_ovf_set", 64'(overflow), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_valid", 64'(mem_req_valid), 64'd0);
      check("t5_rst_we",    64'(refill_we), 64'd0);
      check("t5_rst_busy",  64'(refill_busy), 64'd0);
      check("t5_rst_ovf",   64'(overflow), 64'd0);
      check("t5_rst_raddr", 64'(refill_addr), 64'd0);
      check("t5_rst_rdata", refill_data, 64'd0);
      check("t5_rst_maddr", 64'(mem_req_addr), 64'd0);
      mem_rsp_valid = 1; mem_rsp_data = 64'h12;
      tick();
      mem_rsp_valid = 0;
      check("t5_rst_hold_we", 64'(refill_we), 64'd0);
      rst = 1'b0;
      tick();
      check("t5_post_idle", 64'(refill_busy), 64'd0);
      miss_pulse = 1; miss_addr = 32'h8006;
      tick();
      miss_pulse = 0;
      check("t5_new_addr", 64'(mem_req_addr), 64'h8004);
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
      beat(64'h20, 32'h8004, 1'b0, "t5_n0");
      beat(64'h21, 32'h8005, 1'b0, "t5_n1");
      beat(64'h22, 32'h8006, 1'b0, "t5_n2");
      beat(64'h23, 32'h8007, 1'b1, "t5_n3");
      tick();
      check("t5_no_pending", 64'(refill_busy), 64'd0);
      check("t5_ndone", 64'(n_done), 64'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cache_miss_refill_ctrl.md
CACHE_MISS_REFILL_CTRL -- requirements
Module: cache_miss_refill_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, line/beat address width.
REQ-002 Parameter DATA_W, 64, refill beat data width.
REQ-003 Parameter BEATS, 4, beats per line refill; power of two, >=2.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 miss_pulse  input  1  one-cycle pulse from the falling-edge detector on cache_hit (negedge_cache_hit).
REQ-007 miss_addr  input  ADDR_W  missing address, sampled when miss_pulse=1.
REQ-008 mem_req_valid  output  1  refill request to memory.
REQ-009 mem_req_ready  input  1  memory accepts request.
REQ-010 mem_req_addr  output  ADDR_W  line base address of request.
REQ-011 mem_rsp_valid  input  1  one response beat present.
REQ-012 mem_rsp_data  input  DATA_W  response beat data.
REQ-013 refill_we  output  1  cache write strobe, one per beat.
REQ-014 refill_addr  output  ADDR_W  cache write address (base + beat index).
REQ-015 refill_data  output  DATA_W  cache write data.
REQ-016 refill_busy  output  1  high whenever state != IDLE.
REQ-017 refill_done  output  1  one-cycle pulse at line completion.
REQ-018 clr_overflow  input  1  synchronous clear of overflow.
REQ-019 overflow  output  1  sticky: a miss_pulse was dropped.

Function
REQ-020 States IDLE, REQ, FILL, DONE; state register encoded internally.
REQ-021 Base address = miss_addr with low log2(BEATS) bits cleared, latched on acceptance.
REQ-022 IDLE: miss_pulse=1 -> latch base, next state REQ; else stay IDLE.
REQ-023 REQ: mem_req_valid=1, mem_req_addr=base, both held stable until mem_req_ready=1 sampled; then FILL, beat counter cleared.
REQ-024 FILL: each cycle with mem_rsp_valid=1 registers data; next cycle refill_we=1, refill_data=that beat, refill_addr=base+beat index; counter increments modulo BEATS.
REQ-025 FILL: acceptance of beat BEATS-1 -> DONE; refill_we for the last beat coincides with the first DONE cycle.
REQ-026 DONE lasts exactly one cycle with refill_done=1; next state REQ if pending slot valid (slot loaded into base, cleared), else IDLE.
REQ-027 mem_rsp_valid outside FILL is ignored; no write, no counter change.
REQ-028 One-entry pending slot: miss_pulse while state != IDLE stores miss_addr-derived base if slot empty.
REQ-029 miss_pulse while state != IDLE and slot full: pulse dropped, overflow set; exception: in DONE with slot full, slot is consumed per REQ-026 and the new pulse refills it, no overflow.
REQ-030 clr_overflow=1 clears overflow next cycle; a simultaneous drop event wins (overflow stays 1).
REQ-031 Latency: miss_pulse in IDLE at cycle N -> mem_req_valid=1 at cycle N+1.
REQ-032 refill_we pulses per line = BEATS exactly; refill_addr wraps only within the line base.

Reset
REQ-033 rst=1 immediately forces state IDLE, pending slot empty, beat counter 0, overflow 0.
REQ-034 Reset values: mem_req_valid=0, refill_we=0, refill_done=0, refill_busy=0, overflow=0, mem_req_addr/refill_addr/refill_data=0.
REQ-035 rst mid-refill aborts the line; no further refill_we or refill_done for it.

Verification
REQ-036 miss_pulse, miss_addr=0x1007, mem_req_ready=1 next cycle, 4 back-to-back beats D0..D3 -> mem_req_addr=0x1004; refill_we at 0x1004..0x1007 with D0..D3; single refill_done.
REQ-037 mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_req_addr stable all 5 cycles; no FILL entry.
REQ-038 Beats with 2-cycle gaps plus mem_rsp_valid in IDLE -> only 4 writes, spurious beat ignored.
REQ-039 Second miss_pulse (0x2000) mid-FILL -> after refill_done, REQ for 0x2000 with no IDLE cycle; third pulse while slot full -> overflow=1 until clr_overflow.
REQ-040 rst asserted after beat 2 -> outputs at reset values immediately; new miss_pulse after release starts clean refill with beat index 0.
